mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Sequences the single external memory bus between the instruction-fetch port (IF) and the data-memory port (MEM) of the five-stage core. Holds each pipeline-side request until it is served, returns captured read data, and drives `pause_o` into the hazard/control unit's external-pause input so the whole pipeline freezes while any access is outstanding. Data accesses have priority over fetches, and a bus watchdog converts a hung slave into an error pulse.

## Interface
- `TIMEOUT`, 255: maximum cycles `bus_req_o` stays high without `bus_ack_i` before abort. Legal range 2..65535; counter width 16.
- `clk` in 1: core clock; all state updates on the rising edge.
- `rst` in 1: asynchronous reset, active-high.
- `if_req_i` in 1: fetch request; held stable while `pause_o` is high.
- `if_addr_i` in 32: fetch word address.
- `if_valid_o` out 1: fetch data for the current stall window is captured.
- `if_rdata_o` out 32: captured fetch data.
- `mem_req_i` in 1: data request; held stable while `pause_o` is high.
- `mem_we_i` in 1: 1 = store, 0 = load.
- `mem_be_i` in 4: byte enables for stores.
- `mem_addr_i` in 32: data address.
- `mem_wdata_i` in 32: store data.
- `mem_valid_o` out 1: data access for the current stall window is complete.
- `mem_rdata_o` out 32: captured load data.
- `bus_req_o` out 1: bus request; registered.
- `bus_we_o` out 1: bus write strobe; registered.
- `bus_be_o` out 4: bus byte enables; registered, `4'hF` for fetches.
- `bus_addr_o` out 32: bus address; registered.
- `bus_wdata_o` out 32: bus write data; registered.
- `bus_rdata_i` in 32: bus read data, valid with ack.
- `bus_ack_i` in 1: one-cycle completion from the slave.
- `bus_err_o` out 1: one-cycle pulse on watchdog abort.
- `pause_o` out 1: combinational stall to the control unit.

## Operation
- FSM states:
  - IDLE: nothing on the bus.
  - GNT_MEM: MEM transaction on the bus.
  - GNT_IF: IF transaction on the bus.
- Served flags:
  - `if_srv` drives `if_valid_o`; `mem_srv` drives `mem_valid_o`.
  - Pending IF = `if_req_i & !if_srv`. Pending MEM = `mem_req_i & !mem_srv`.
  - `pause_o` = pending IF | pending MEM.
- IDLE:
  - Pending MEM goes to GNT_MEM; otherwise pending IF goes to GNT_IF.
  - On grant, the bus registers capture the granted port's address, data, we and be, and `bus_req_o` is set.
  - Watchdog counter clears to 0.
- GNT_x with `bus_ack_i`:
  - Capture `bus_rdata_i` into x's rdata register and set x's served flag.
  - Clear `bus_req_o`, unless the other port is pending; then grant it directly (back-to-back, no IDLE cycle), load the bus registers and clear the counter.
- GNT_x without ack: counter increments. When the counter equals `TIMEOUT-1`:
  - Abort and clear `bus_req_o`.
  - Set x's served flag with rdata = 0.
  - Pulse `bus_err_o` in the following cycle.
  - Next state follows the same rules as an ack.
- Served flags clear at any edge where `pause_o` = 0, because the pipeline advances. A flag also clears when its own request is low.
- Request withdrawn while granted (flush): the bus transaction still runs to ack or abort. Its result is discarded and no served flag is set.
- Store ack: rdata is still captured (don't-care to the pipeline).
- Reset values: state IDLE, both served flags 0, both rdata 0, all `bus_*` outputs 0, counter 0, `bus_err_o` 0. `pause_o` follows its equation (0 if no requests).
- `rst` asserted mid-transaction drops `bus_req_o` immediately. Slaves must tolerate an abandoned request.

## Timing
- `pause_o` rises in the same cycle as a new request (combinational).
- A single access with a zero-wait slave:
  - Request at cycle 0.
  - `bus_req_o` high in cycle 1, ack in cycle 1.
  - Valid flag high in cycle 2, `pause_o` low in cycle 2.
  - Result: 2 stall cycles. Each slave wait state adds 1.
- Simultaneous IF+MEM with zero-wait slave:
  - MEM on bus in cycle 1, IF on bus in cycle 2.
  - Both valid and `pause_o` low in cycle 3.
- Bus outputs are stable from grant until ack or abort. `bus_req_o` never glitches.
- `bus_ack_i` is ignored in IDLE.

## Test plan
- Reset: assert `rst` asynchronously mid-GNT_IF. `bus_req_o`, `if_valid_o`, `bus_err_o`, the rdata outputs and the counter go to 0 before the next edge. `pause_o` is 0 once requests are released.
- Lone fetch: `if_req_i`=1, addr `0xBFC00000`, ack in cycle 1 with `0x24080001`. `bus_be_o`=`F`, `if_rdata_o`=`0x24080001` in cycle 2, `pause_o` high in cycles 0–1 only.
- Contention: IF `0x00400010` and store MEM `0x10000000`, `be`=`0011`, wdata `0xDEADBEEF`. MEM is granted first with `bus_we_o`=1, then IF with no IDLE gap. `pause_o` falls in cycle 3.
- Wait states: load from `0x10000004`, ack after 5 wait cycles with `0x12345678`. Stall lasts 7 cycles and `mem_rdata_o`=`0x12345678`.
- Watchdog: `TIMEOUT`=4, no ack. Abort after 4 bus cycles, one `bus_err_o` pulse, `mem_rdata_o`=0, `pause_o` released.
- Flush: drop `mem_req_i` while granted, then ack. `mem_valid_o` stays 0 and a later IF request is granted normally.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single external memory bus between the fetch (IF) and data (MEM)
// ports, freezing the pipeline via pause_o until every live request is served.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_valid_o,
  output logic [31:0] if_rdata_o,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_be_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic        mem_valid_o,
  output logic [31:0] mem_rdata_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic        bus_err_o,
  output logic        pause_o
);

  typedef enum logic [1:0] {
    IDLE,
    GNT_MEM,
    GNT_IF
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_d;
  logic        if_srv, mem_srv;
  logic [15:0] cnt;
  logic        pend_if, pend_mem;
  logic        load_if, load_mem;
  logic        done, abort, own_req;

  assign pend_if     = if_req_i & ~if_srv;
  assign pend_mem    = mem_req_i & ~mem_srv;
  assign pause_o     = pend_if | pend_mem;
  assign if_valid_o  = if_srv;
  assign mem_valid_o = mem_srv;

  always_comb begin
    state_d  = state;
    load_if  = 1'b0;
    load_mem = 1'b0;
    done     = 1'b0;
    abort    = 1'b0;
    own_req  = 1'b0;
    unique case (state)
      IDLE: begin
        if (pend_mem) begin
          state_d  = GNT_MEM;
          load_mem = 1'b1;
        end else if (pend_if) begin
          state_d = GNT_IF;
          load_if = 1'b1;
        end
      end
      GNT_MEM: begin
        own_req = mem_req_i;
        if (bus_ack_i || (cnt == CNT_LAST)) begin
          done  = 1'b1;
          abort = ~bus_ack_i;
          if (pend_if) begin
            state_d = GNT_IF;
            load_if = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GNT_IF: begin
        own_req = if_req_i;
        if (bus_ack_i || (cnt == CNT_LAST)) begin
          done  = 1'b1;
          abort = ~bus_ack_i;
          if (pend_mem) begin
            state_d  = GNT_MEM;
            load_mem = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Bus registers and watchdog counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_be_o    <= '0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
      bus_err_o   <= 1'b0;
      cnt         <= '0;
    end else begin
      bus_err_o <= done & abort;
      if (load_mem) begin
        bus_req_o   <= 1'b1;
        bus_we_o    <= mem_we_i;
        bus_be_o    <= mem_be_i;
        bus_addr_o  <= mem_addr_i;
        bus_wdata_o <= mem_wdata_i;
        cnt         <= '0;
      end else if (load_if) begin
        bus_req_o   <= 1'b1;
        bus_we_o    <= 1'b0;
        bus_be_o    <= '1;
        bus_addr_o  <= if_addr_i;
        bus_wdata_o <= '0;
        cnt         <= '0;
      end else if (done) begin
        bus_req_o <= 1'b0;
      end else if (state == IDLE) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end

  // A completion whose request was withdrawn mid-flight (flush) is dropped entirely.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_srv      <= 1'b0;
      mem_srv     <= 1'b0;
      if_rdata_o  <= '0;
      mem_rdata_o <= '0;
    end else begin
      if (!pause_o || !if_req_i)  if_srv  <= 1'b0;
      if (!pause_o || !mem_req_i) mem_srv <= 1'b0;
      if (done && own_req) begin
        if (state == GNT_IF) begin
          if_srv     <= 1'b1;
          if_rdata_o <= abort ? '0 : bus_rdata_i;
        end else begin
          mem_srv     <= 1'b1;
          mem_rdata_o <= abort ? '0 : bus_rdata_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scenario bench for mem_bus_arbiter: a modelled bus slave logs completed transfers,
// which each scenario compares against transfers and read data it queued up front.
module tb_mem_bus_arbiter;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic        if_valid_o;
  logic [31:0] if_rdata_o;
  logic        mem_req_i = 1'b0, mem_we_i = 1'b0;
  logic [3:0]  mem_be_i = '0;
  logic [31:0] mem_addr_i = '0, mem_wdata_i = '0;
  logic        mem_valid_o;
  logic [31:0] mem_rdata_o;
  logic        bus_req_o, bus_we_o, bus_err_o, pause_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;

  logic        w_if_req_i = 1'b0;
  logic [31:0] w_if_addr_i = '0;
  logic        w_if_valid_o;
  logic [31:0] w_if_rdata_o;
  logic        w_mem_req_i = 1'b0, w_mem_we_i = 1'b0;
  logic [3:0]  w_mem_be_i = '0;
  logic [31:0] w_mem_addr_i = '0, w_mem_wdata_i = '0;
  logic        w_mem_valid_o;
  logic [31:0] w_mem_rdata_o;
  logic        w_bus_req_o, w_bus_we_o, w_bus_err_o, w_pause_o;
  logic [3:0]  w_bus_be_o;
  logic [31:0] w_bus_addr_o, w_bus_wdata_o;
  logic [31:0] w_bus_rdata_i = 32'hFFFF_FFFF;
  logic        w_bus_ack_i = 1'b0;

  mem_bus_arbiter #(.TIMEOUT(255)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_valid_o(if_valid_o), .if_rdata_o(if_rdata_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_be_i(mem_be_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_valid_o(mem_valid_o), .mem_rdata_o(mem_rdata_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_be_o(bus_be_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i),
    .bus_err_o(bus_err_o), .pause_o(pause_o)
  );

  // Second instance with a short watchdog; its bus never acknowledges.
  mem_bus_arbiter #(.TIMEOUT(4)) dut_wd (
    .clk(clk), .rst(rst),
    .if_req_i(w_if_req_i), .if_addr_i(w_if_addr_i), .if_valid_o(w_if_valid_o), .if_rdata_o(w_if_rdata_o),
    .mem_req_i(w_mem_req_i), .mem_we_i(w_mem_we_i), .mem_be_i(w_mem_be_i), .mem_addr_i(w_mem_addr_i),
    .mem_wdata_i(w_mem_wdata_i), .mem_valid_o(w_mem_valid_o), .mem_rdata_o(w_mem_rdata_o),
    .bus_req_o(w_bus_req_o), .bus_we_o(w_bus_we_o), .bus_be_o(w_bus_be_o), .bus_addr_o(w_bus_addr_o),
    .bus_wdata_o(w_bus_wdata_o), .bus_rdata_i(w_bus_rdata_i), .bus_ack_i(w_bus_ack_i),
    .bus_err_o(w_bus_err_o), .pause_o(w_pause_o)
  );

  int   errors = 0;
  int   checks = 0;
  txn_t exp_txn[$];
  txn_t obs_txn[$];
  logic [31:0] exp_if[$];
  logic [31:0] exp_mem[$];

  function automatic logic [31:0] slave_data(input logic [31:0] a);
    case (a)
      32'hBFC0_0000: return 32'h2408_0001;
      32'h1000_0004: return 32'h1234_5678;
      default:       return a ^ 32'hA5A5_A5A5;
    endcase
  endfunction

  // Slave: acks after slave_wait wait states; drives junk on rdata outside ack.
  int   slave_wait = 0;
  int   wcnt = 0;
  logic slave_prev;
  txn_t slave_t;
  always begin
    @(posedge clk);
    #2;
    slave_prev  = bus_ack_i;
    bus_ack_i   = 1'b0;
    bus_rdata_i = 32'hBAD0_BAD0;
    if (bus_req_o) begin
      if (slave_prev) wcnt = 0;
      if (wcnt == slave_wait) begin
        bus_ack_i   = 1'b1;
        bus_rdata_i = slave_data(bus_addr_o);
        slave_t     = {bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o};
        obs_txn.push_back(slave_t);
      end
      wcnt++;
    end else begin
      wcnt = 0;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_power_on();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus_req_o, bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o, bus_err_o} !== '0) begin
      errors++;
      $display("FAIL reset_bus: got req=%b we=%b be=%h addr=%h wdata=%h err=%b required all 0",
               bus_req_o, bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o, bus_err_o);
    end
    checks++;
    if ({if_valid_o, mem_valid_o, if_rdata_o, mem_rdata_o, pause_o} !== '0) begin
      errors++;
      $display("FAIL reset_port: got ifv=%b memv=%b ifd=%h memd=%h pause=%b required all 0",
               if_valid_o, mem_valid_o, if_rdata_o, mem_rdata_o, pause_o);
    end
    next_cycle();
    rst = 1'b0;
    repeat (2) next_cycle();
  endtask

  task automatic test_lone_fetch();
    txn_t o, e;
    slave_wait = 0;
    next_cycle();
    if_addr_i = 32'hBFC0_0000;
    if_req_i  = 1'b1;
    exp_txn.push_back({1'b0, 4'hF, 32'hBFC0_0000, 32'h0});
    exp_if.push_back(32'h2408_0001);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (pause_o !== (c < 2)) begin
        errors++;
        $display("FAIL fetch_pause c%0d: got %b required %b", c, pause_o, (c < 2));
      end
      if (c == 1) begin
        checks++;
        if ({bus_req_o, bus_we_o, bus_be_o, bus_addr_o} !== {1'b1, 1'b0, 4'hF, 32'hBFC0_0000}) begin
          errors++;
          $display("FAIL fetch_bus: got req=%b we=%b be=%h addr=%h required 1 0 f bfc00000",
                   bus_req_o, bus_we_o, bus_be_o, bus_addr_o);
        end
      end
      if (c == 2) begin
        checks++;
        if (if_valid_o !== 1'b1 || exp_if.size() == 0 || if_rdata_o !== exp_if[0]) begin
          errors++;
          $display("FAIL fetch_data: got valid=%b data=%h required 1 24080001", if_valid_o, if_rdata_o);
        end
        if (exp_if.size() != 0) void'(exp_if.pop_front());
      end
      if (c == 3) begin
        checks++;
        if (if_valid_o !== 1'b0) begin
          errors++;
          $display("FAIL fetch_valid_clear: got %b required 0", if_valid_o);
        end
      end
      next_cycle();
      if (c == 2) if_req_i = 1'b0;
    end
    while (exp_txn.size() != 0) begin
      e = exp_txn.pop_front();
      checks++;
      if (obs_txn.size() == 0) begin
        errors++;
        $display("FAIL fetch_txn: got none required %h", e);
      end else begin
        o = obs_txn.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL fetch_txn: got %h required %h", o, e);
        end
      end
    end
  endtask

  task automatic test_contention();
    txn_t o, e;
    slave_wait = 0;
    next_cycle();
    if_addr_i   = 32'h0040_0010;
    if_req_i    = 1'b1;
    mem_addr_i  = 32'h1000_0000;
    mem_we_i    = 1'b1;
    mem_be_i    = 4'b0011;
    mem_wdata_i = 32'hDEAD_BEEF;
    mem_req_i   = 1'b1;
    exp_txn.push_back({1'b1, 4'b0011, 32'h1000_0000, 32'hDEAD_BEEF});
    exp_txn.push_back({1'b0, 4'hF, 32'h0040_0010, 32'h0});
    exp_if.push_back(32'h0040_0010 ^ 32'hA5A5_A5A5);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (pause_o !== (c < 3)) begin
        errors++;
        $display("FAIL cont_pause c%0d: got %b required %b", c, pause_o, (c < 3));
      end
      if (c == 1) begin
        checks++;
        if ({bus_req_o, bus_we_o, bus_be_o, bus_addr_o} !== {1'b1, 1'b1, 4'b0011, 32'h1000_0000}) begin
          errors++;
          $display("FAIL cont_mem_first: got req=%b we=%b be=%h addr=%h required 1 1 3 10000000",
                   bus_req_o, bus_we_o, bus_be_o, bus_addr_o);
        end
      end
      if (c == 2) begin
        checks++;
        if ({bus_req_o, bus_we_o, bus_addr_o, mem_valid_o} !== {1'b1, 1'b0, 32'h0040_0010, 1'b1}) begin
          errors++;
          $display("FAIL cont_if_b2b: got req=%b we=%b addr=%h memv=%b required 1 0 00400010 1",
                   bus_req_o, bus_we_o, bus_addr_o, mem_valid_o);
        end
      end
      if (c == 3) begin
        checks++;
        if (if_valid_o !== 1'b1 || mem_valid_o !== 1'b1 || exp_if.size() == 0 || if_rdata_o !== exp_if[0]) begin
          errors++;
          $display("FAIL cont_done: got ifv=%b memv=%b ifd=%h required 1 1 a5e5a5b5",
                   if_valid_o, mem_valid_o, if_rdata_o);
        end
        if (exp_if.size() != 0) void'(exp_if.pop_front());
      end
      next_cycle();
      if (c == 3) begin
        if_req_i  = 1'b0;
        mem_req_i = 1'b0;
        mem_we_i  = 1'b0;
      end
    end
    while (exp_txn.size() != 0) begin
      e = exp_txn.pop_front();
      checks++;
      if (obs_txn.size() == 0) begin
        errors++;
        $display("FAIL cont_txn: got none required %h", e);
      end else begin
        o = obs_txn.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL cont_txn: got %h required %h", o, e);
        end
      end
    end
  endtask

  task automatic test_wait_states();
    txn_t o, e;
    int   stall;
    bit   released;
    stall      = 0;
    released   = 1'b0;
    slave_wait = 5;
    next_cycle();
    mem_addr_i  = 32'h1000_0004;
    mem_we_i    = 1'b0;
    mem_be_i    = 4'hF;
    mem_wdata_i = '0;
    mem_req_i   = 1'b1;
    exp_txn.push_back({1'b0, 4'hF, 32'h1000_0004, 32'h0});
    exp_mem.push_back(32'h1234_5678);
    for (int c = 0; c < 30 && !released; c++) begin
      @(negedge clk);
      if (pause_o) begin
        stall++;
        if (c >= 1) begin
          checks++;
          if ({bus_req_o, bus_addr_o} !== {1'b1, 32'h1000_0004}) begin
            errors++;
            $display("FAIL wait_bus_stable c%0d: got req=%b addr=%h required 1 10000004", c, bus_req_o, bus_addr_o);
          end
        end
        next_cycle();
      end else begin
        released = 1'b1;
      end
    end
    checks++;
    if (!released || stall != 7) begin
      errors++;
      $display("FAIL wait_stall: got released=%b stall=%0d required 1 7", released, stall);
    end
    checks++;
    if (mem_valid_o !== 1'b1 || exp_mem.size() == 0 || mem_rdata_o !== exp_mem[0]) begin
      errors++;
      $display("FAIL wait_data: got valid=%b data=%h required 1 12345678", mem_valid_o, mem_rdata_o);
    end
    if (exp_mem.size() != 0) void'(exp_mem.pop_front());
    next_cycle();
    mem_req_i  = 1'b0;
    slave_wait = 0;
    repeat (2) next_cycle();
    while (exp_txn.size() != 0) begin
      e = exp_txn.pop_front();
      checks++;
      if (obs_txn.size() == 0) begin
        errors++;
        $display("FAIL wait_txn: got none required %h", e);
      end else begin
        o = obs_txn.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL wait_txn: got %h required %h", o, e);
        end
      end
    end
  endtask

  task automatic test_watchdog();
    int req_cycles;
    int err_cycles;
    int err_at;
    req_cycles = 0;
    err_cycles = 0;
    err_at     = -1;
    next_cycle();
    w_mem_addr_i = 32'h1000_0008;
    w_mem_we_i   = 1'b0;
    w_mem_be_i   = 4'hF;
    w_mem_req_i  = 1'b1;
    exp_mem.push_back(32'h0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (w_bus_req_o) req_cycles++;
      if (w_bus_err_o) begin
        err_cycles++;
        err_at = c;
      end
      if (c == 5) begin
        checks++;
        if (w_mem_valid_o !== 1'b1 || w_pause_o !== 1'b0 || exp_mem.size() == 0 || w_mem_rdata_o !== exp_mem[0]) begin
          errors++;
          $display("FAIL wd_abort: got valid=%b pause=%b data=%h required 1 0 00000000",
                   w_mem_valid_o, w_pause_o, w_mem_rdata_o);
        end
        if (exp_mem.size() != 0) void'(exp_mem.pop_front());
      end
      next_cycle();
      if (c == 5) w_mem_req_i = 1'b0;
    end
    checks++;
    if (req_cycles != 4) begin
      errors++;
      $display("FAIL wd_bus_cycles: got %0d required 4", req_cycles);
    end
    checks++;
    if (err_cycles != 1 || err_at != 5) begin
      errors++;
      $display("FAIL wd_err_pulse: got count=%0d at=%0d required 1 at 5", err_cycles, err_at);
    end
  endtask

  task automatic test_flush();
    txn_t o, e;
    bit   got;
    got        = 1'b0;
    slave_wait = 3;
    next_cycle();
    mem_addr_i  = 32'h1000_0020;
    mem_we_i    = 1'b0;
    mem_be_i    = 4'hF;
    mem_wdata_i = '0;
    mem_req_i   = 1'b1;
    exp_txn.push_back({1'b0, 4'hF, 32'h1000_0020, 32'h0});
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 1) begin
        checks++;
        if (bus_req_o !== 1'b1) begin
          errors++;
          $display("FAIL flush_grant: got %b required 1", bus_req_o);
        end
      end
      if (c == 2) begin
        checks++;
        if ({pause_o, bus_req_o} !== 2'b01) begin
          errors++;
          $display("FAIL flush_pause: got pause=%b req=%b required 0 1", pause_o, bus_req_o);
        end
      end
      if (c >= 2) begin
        checks++;
        if (mem_valid_o !== 1'b0) begin
          errors++;
          $display("FAIL flush_valid c%0d: got %b required 0", c, mem_valid_o);
        end
      end
      if (c == 5) begin
        checks++;
        if (bus_req_o !== 1'b0) begin
          errors++;
          $display("FAIL flush_bus_done: got %b required 0", bus_req_o);
        end
      end
      next_cycle();
      if (c == 1) mem_req_i = 1'b0;
    end
    slave_wait = 0;
    if_addr_i  = 32'h0040_0020;
    if_req_i   = 1'b1;
    exp_txn.push_back({1'b0, 4'hF, 32'h0040_0020, 32'h0});
    exp_if.push_back(32'h0040_0020 ^ 32'hA5A5_A5A5);
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (if_valid_o) got = 1'b1;
      else next_cycle();
    end
    checks++;
    if (!got || exp_if.size() == 0 || if_rdata_o !== exp_if[0]) begin
      errors++;
      $display("FAIL flush_later_fetch: got valid=%b data=%h required 1 a5e5a585", got, if_rdata_o);
    end
    if (exp_if.size() != 0) void'(exp_if.pop_front());
    next_cycle();
    if_req_i = 1'b0;
    repeat (2) next_cycle();
    while (exp_txn.size() != 0) begin
      e = exp_txn.pop_front();
      checks++;
      if (obs_txn.size() == 0) begin
        errors++;
        $display("FAIL flush_txn: got none required %h", e);
      end else begin
        o = obs_txn.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL flush_txn: got %h required %h", o, e);
        end
      end
    end
  endtask

  task automatic test_reset();
    slave_wait = 10;
    next_cycle();
    if_addr_i = 32'h0040_0040;
    if_req_i  = 1'b1;
    repeat (3) next_cycle();
    @(negedge clk);
    checks++;
    if ({bus_req_o, bus_addr_o} !== {1'b1, 32'h0040_0040}) begin
      errors++;
      $display("FAIL rst_pre_grant: got req=%b addr=%h required 1 00400040", bus_req_o, bus_addr_o);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({bus_req_o, if_valid_o, bus_err_o, if_rdata_o, mem_rdata_o} !== '0) begin
      errors++;
      $display("FAIL rst_async: got req=%b ifv=%b err=%b ifd=%h memd=%h required all 0",
               bus_req_o, if_valid_o, bus_err_o, if_rdata_o, mem_rdata_o);
    end
    checks++;
    if (dut.cnt !== 16'd0) begin
      errors++;
      $display("FAIL rst_counter: got %0d required 0", dut.cnt);
    end
    if_req_i = 1'b0;
    #1;
    checks++;
    if (pause_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_pause: got %b required 0", pause_o);
    end
    next_cycle();
    rst        = 1'b0;
    slave_wait = 0;
    repeat (2) next_cycle();
    checks++;
    if (obs_txn.size() != 0) begin
      errors++;
      $display("FAIL rst_stray_txn: got %0d required 0", obs_txn.size());
    end
  endtask

  initial begin
    test_power_on();
    test_lone_fetch();
    test_contention();
    test_wait_states();
    test_watchdog();
    test_flush();
    test_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL global_timeout: got no completion required finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "simulation time limit reached");
  end

endmodule
